// File: rtl/rs_bm_solver_if.sv
// rtl/rs_bm_solver_if.sv - syndrome-in / locator-out bus of the RS key-equation solver
interface rs_bm_solver_if #(
  parameter int T = 8
);
  logic [16*T-1:0]    syndrome_in;
  logic               valid_in;
  logic               in_ready;
  logic [8*(T+1)-1:0] lambda_out;
  logic [3:0]         lambda_len;
  logic               fail_out;
  logic               valid_out;

  modport master (
    output syndrome_in, valid_in,
    input  in_ready, lambda_out, lambda_len, fail_out, valid_out
  );

  modport slave (
    input  syndrome_in, valid_in,
    output in_ready, lambda_out, lambda_len, fail_out, valid_out
  );
endinterface

// File: rtl/rs_bm_solver.sv
// rtl/rs_bm_solver.sv - inversionless Berlekamp-Massey key-equation solver over GF(2^8); optional RS_BM_FAIL_CNT_EN adds a failure counter
module rs_bm_solver #(
  parameter int T = 8
) (
  input logic           clk,
  input logic           rst_n,
  rs_bm_solver_if.slave bus
`ifdef RS_BM_FAIL_CNT_EN
  ,
  output logic [15:0]   fail_cnt
`endif
);

  localparam int NS = 2 * T;
  localparam int RW = $clog2(NS);
  localparam int LW = RW + 1;

  typedef enum logic [1:0] {IDLE, ITER, CHECK} state_t;

  state_t          state, state_next;
  logic [7:0]      synd [NS];
  logic [7:0]      lam [T+1];
  logic [7:0]      b [T+1];
  logic [7:0]      gamma;
  logic [LW-1:0]   l_reg;
  logic [RW-1:0]   r_reg;

  logic [7:0]      delta;
  logic [RW-1:0]   idx;
  logic [7:0]      lam_upd [T+1];
  logic [7:0]      b_upd [T+1];
  logic [7:0]      gamma_upd;
  logic [LW-1:0]   l_upd;
  logic [LW-1:0]   deg;
  logic            fail_now;

  logic [8*(T+1)-1:0] lambda_q;
  logic [3:0]         len_q;
  logic               fail_q;
  logic               valid_q;

  // GF(2^8) multiply, primitive polynomial x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign bus.in_ready   = (state == IDLE);
  assign bus.lambda_out = lambda_q;
  assign bus.lambda_len = len_q;
  assign bus.fail_out   = fail_q;
  assign bus.valid_out  = valid_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: one ITER cycle per syndrome, then a single CHECK cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.valid_in) state_next = ITER;
      ITER:    if (r_reg == RW'(NS - 1)) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iBM iteration: discrepancy, locator update and auxiliary polynomial update
  always_comb begin
    delta = '0;
    idx   = '0;
    for (int i = 0; i <= T; i++) begin
      if (RW'(i) <= r_reg) begin
        idx   = r_reg - RW'(i);
        delta = delta ^ gf_mul(lam[i], synd[idx]);
      end
    end
    lam_upd[0] = gf_mul(gamma, lam[0]);
    for (int i = 1; i <= T; i++) lam_upd[i] = gf_mul(gamma, lam[i]) ^ gf_mul(delta, b[i-1]);
    if ((delta != 8'h00) && ({1'b0, l_reg, 1'b0} <= {2'b00, r_reg})) begin
      for (int i = 0; i <= T; i++) b_upd[i] = lam[i];
      l_upd     = LW'({1'b0, r_reg}) + LW'(1) - l_reg;
      gamma_upd = delta;
    end else begin
      b_upd[0] = 8'h00;
      for (int i = 1; i <= T; i++) b_upd[i] = b[i-1];
      l_upd     = l_reg;
      gamma_upd = gamma;
    end
  end

  // Declared length must equal the actual degree and stay within correction capability
  always_comb begin
    deg = '0;
    for (int i = 0; i <= T; i++) begin
      if (lam[i] != 8'h00) deg = LW'(i);
    end
    fail_now = (l_reg > LW'(T)) || (deg != l_reg);
  end

  // Datapath registers: syndrome latch, iteration state and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) synd[k] <= '0;
      for (int i = 0; i <= T; i++) begin
        lam[i] <= '0;
        b[i]   <= '0;
      end
      gamma    <= '0;
      l_reg    <= '0;
      r_reg    <= '0;
      lambda_q <= '0;
      len_q    <= '0;
      fail_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef RS_BM_FAIL_CNT_EN
      fail_cnt <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            for (int k = 0; k < NS; k++) synd[k] <= bus.syndrome_in[8*k +: 8];
            lam[0] <= 8'h01;
            b[0]   <= 8'h01;
            for (int i = 1; i <= T; i++) begin
              lam[i] <= '0;
              b[i]   <= '0;
            end
            gamma <= 8'h01;
            l_reg <= '0;
            r_reg <= '0;
          end
        end
        ITER: begin
          for (int i = 0; i <= T; i++) begin
            lam[i] <= lam_upd[i];
            b[i]   <= b_upd[i];
          end
          gamma <= gamma_upd;
          l_reg <= l_upd;
          r_reg <= r_reg + RW'(1);
        end
        CHECK: begin
          for (int i = 0; i <= T; i++) lambda_q[8*i +: 8] <= lam[i];
          len_q   <= l_reg[3:0];
          fail_q  <= fail_now;
          valid_q <= 1'b1;
`ifdef RS_BM_FAIL_CNT_EN
          if (fail_now && (fail_cnt != 16'hFFFF)) fail_cnt <= fail_cnt + 16'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_bm_solver.sv
// tb/tb_rs_bm_solver.sv - directed self-checking bench for rs_bm_solver
module tb_rs_bm_solver;

  localparam int T = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  rs_bm_solver_if #(.T(T)) bus ();

`ifdef RS_BM_FAIL_CNT_EN
  logic [15:0] fail_cnt;
`endif

  rs_bm_solver #(.T(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef RS_BM_FAIL_CNT_EN
    ,
    .fail_cnt (fail_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [16*T-1:0] synd_const(input logic [7:0] v);
    logic [16*T-1:0] s;
    for (int k = 0; k < 2*T; k++) s[8*k +: 8] = v;
    return s;
  endfunction

  // S_k = y * (alpha^j)^k
  function automatic logic [16*T-1:0] synd_single(input logic [7:0] y, input int j);
    logic [16*T-1:0] s;
    logic [7:0]      v;
    logic [7:0]      x;
    x = 8'h01;
    for (int n = 0; n < j; n++) x = tb_gf_mul(x, 8'h02);
    v = y;
    for (int k = 0; k < 2*T; k++) begin
      s[8*k +: 8] = v;
      v = tb_gf_mul(v, x);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [16*T-1:0] s);
    bus.syndrome_in = s;
    bus.valid_in    = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in    = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        lat = n;
        break;
      end
    end
  endtask

  int              lat;
  int              n_valid;
  int              first_e;
  int              second_e;
  logic [71:0]     first_lam;
  logic            first_fail;
  logic [71:0]     second_lam;
  logic [3:0]      second_len;
  logic [16*T-1:0] s0_only;
  logic [7:0]      lam0;
  logic [7:0]      lam1;

  initial begin
    tests           = 0;
    failed          = 0;
    rst_n           = 1'b0;
    bus.valid_in    = 1'b0;
    bus.syndrome_in = '0;
    s0_only         = '0;
    s0_only[7:0]    = 8'h01;

    #2;
    check("rst_lambda", bus.lambda_out, 72'h0);
    check("rst_len", bus.lambda_len, 4'h0);
    check("rst_fail", bus.fail_out, 1'b0);
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_ready", bus.in_ready, 1'b1);
`ifdef RS_BM_FAIL_CNT_EN
    check("rst_fail_cnt", fail_cnt, 16'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero syndromes: no errors
    send(synd_const(8'h00));
    check("zero_busy", bus.in_ready, 1'b0);
    wait_valid(lat);
    check("zero_latency", lat, 17);
    check("zero_lambda", bus.lambda_out, 72'h01);
    check("zero_len", bus.lambda_len, 4'd0);
    check("zero_fail", bus.fail_out, 1'b0);
    @(posedge clk);
    #1;
    check("zero_pulse_clear", bus.valid_out, 1'b0);
    check("zero_held_lambda", bus.lambda_out, 72'h01);

    // Single error, magnitude 1 at position 0
    send(synd_const(8'h01));
    wait_valid(lat);
    check("one_latency", lat, 17);
    check("one_lambda", bus.lambda_out, 72'h0101);
    check("one_len", bus.lambda_len, 4'd1);
    check("one_fail", bus.fail_out, 1'b0);

    // Only S_0 nonzero: inconsistent, deg 0 vs L 1
`ifdef RS_BM_FAIL_CNT_EN
    check("cnt_before", fail_cnt, 16'd0);
`endif
    send(s0_only);
    wait_valid(lat);
    check("s0_latency", lat, 17);
    check("s0_lambda", bus.lambda_out, 72'h01);
    check("s0_len", bus.lambda_len, 4'd1);
    check("s0_fail", bus.fail_out, 1'b1);
`ifdef RS_BM_FAIL_CNT_EN
    check("cnt_after", fail_cnt, 16'd1);
`endif

    // Single error at position 5, magnitude 0x37: root ratio alpha^5 = 0x20
    send(synd_single(8'h37, 5));
    wait_valid(lat);
    check("pos5_latency", lat, 17);
    check("pos5_len", bus.lambda_len, 4'd1);
    check("pos5_fail", bus.fail_out, 1'b0);
    lam0 = bus.lambda_out[7:0];
    lam1 = bus.lambda_out[15:8];
    check("pos5_lam0_nonzero", (lam0 != 8'h00), 1'b1);
    check("pos5_ratio", lam1, tb_gf_mul(lam0, 8'h20));
    check("pos5_upper", bus.lambda_out[71:16], 56'h0);

    // Busy-time valid_in ignored; next legal acceptance at k+18
    send(synd_const(8'h00));
    n_valid    = 0;
    first_e    = -1;
    second_e   = -1;
    first_lam  = '0;
    first_fail = 1'b1;
    second_lam = '0;
    second_len = '0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 5) begin
        bus.syndrome_in = s0_only;
        bus.valid_in    = 1'b1;
      end
      if (e == 18) begin
        bus.syndrome_in = synd_const(8'h01);
        bus.valid_in    = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      if (bus.valid_out) begin
        n_valid++;
        if (n_valid == 1) begin
          first_e    = e;
          first_lam  = bus.lambda_out;
          first_fail = bus.fail_out;
        end else if (n_valid == 2) begin
          second_e   = e;
          second_lam = bus.lambda_out;
          second_len = bus.lambda_len;
        end
      end
    end
    check("busy_count", n_valid, 2);
    check("busy_first_edge", first_e, 17);
    check("busy_first_lambda", first_lam, 72'h01);
    check("busy_first_fail", first_fail, 1'b0);
    check("busy_second_edge", second_e, 35);
    check("busy_second_lambda", second_lam, 72'h0101);
    check("busy_second_len", second_len, 4'd1);

    // Asynchronous reset at r=7 aborts the codeword
    send(synd_single(8'h37, 5));
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_lambda", bus.lambda_out, 72'h0);
    check("abort_len", bus.lambda_len, 4'd0);
    check("abort_ready", bus.in_ready, 1'b1);
    check("abort_valid", bus.valid_out, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    n_valid = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) n_valid++;
    end
    check("abort_no_valid", n_valid, 0);
    send(synd_const(8'h01));
    wait_valid(lat);
    check("post_latency", lat, 17);
    check("post_lambda", bus.lambda_out, 72'h0101);
    check("post_fail", bus.fail_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
